// File: rtl/pwm_fade_sequencer.sv
// Fades a registered PWM duty toward accepted targets one LSB per ramp tick; cmd_ready only in IDLE with ena, commands never queued.
// Optional triangle "breathe" mode with extra input breathe_i is compiled in when PWM_FADE_BREATHE_EN is defined.
module pwm_fade_sequencer #(
  parameter int N          = 8,
  parameter int PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena_i,
  input  logic [PRESCALE_W-1:0] prescale_i,
  input  logic [7:0]            ramp_div_i,
  input  logic                  cmd_valid_i,
  input  logic [N-1:0]          cmd_target_i,
`ifdef PWM_FADE_BREATHE_EN
  input  logic                  breathe_i,
`endif
  output logic                  cmd_ready_o,
  output logic                  step_o,
  output logic [N-1:0]          duty_o,
  output logic                  busy_o,
  output logic                  done_o
);

`ifdef PWM_FADE_BREATHE_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RAMP = 2'd1, S_BUP = 2'd2, S_BDOWN = 2'd3} state_e;
  localparam logic [N-1:0] DUTY_TOP    = '1;
  localparam logic [N-1:0] DUTY_TOP_M1 = DUTY_TOP - 1'b1;
  localparam logic [N-1:0] DUTY_ONE    = {{(N-1){1'b0}}, 1'b1};
`else
  typedef enum logic [0:0] {S_IDLE = 1'b0, S_RAMP = 1'b1} state_e;
`endif

  state_e                state_q, state_d;
  logic [PRESCALE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic                  step_q, step_d;
  logic [7:0]            div_q, div_d;
  logic [N-1:0]          duty_q, duty_d;
  logic [N-1:0]          target_q, target_d;
  logic                  done_q, done_d;
  logic                  busy;
  logic                  ramp_tick;
  logic                  div_clr;

  assign busy = (state_q != S_IDLE);

`ifdef PWM_FADE_BREATHE_EN
  assign cmd_ready_o = (state_q == S_IDLE) && ena_i && !breathe_i;
`else
  assign cmd_ready_o = (state_q == S_IDLE) && ena_i;
`endif

  // A count left above a freshly lowered prescale wraps silently, without a step.
  always_comb begin
    pre_cnt_d = pre_cnt_q;
    step_d    = 1'b0;
    if (ena_i) begin
      if (pre_cnt_q == prescale_i) begin
        pre_cnt_d = '0;
        step_d    = 1'b1;
      end else if (pre_cnt_q > prescale_i) begin
        pre_cnt_d = '0;
      end else begin
        pre_cnt_d = pre_cnt_q + 1'b1;
      end
    end
  end

  assign ramp_tick = ena_i && busy && step_q && (div_q == ramp_div_i);

  always_comb begin
    div_d = div_q;
    if (ena_i) begin
      if (div_clr) begin
        div_d = '0;
      end else if (busy && step_q) begin
        if (div_q >= ramp_div_i) div_d = '0;
        else                     div_d = div_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    duty_d   = duty_q;
    target_d = target_q;
    done_d   = 1'b0;
    div_clr  = 1'b0;
    if (ena_i) begin
      case (state_q)
        S_IDLE: begin
`ifdef PWM_FADE_BREATHE_EN
          if (breathe_i) begin
            state_d = S_BUP;
            div_clr = 1'b1;
          end else
`endif
          if (cmd_valid_i) begin
            target_d = cmd_target_i;
            if (cmd_target_i == duty_q) begin
              done_d = 1'b1;
            end else begin
              state_d = S_RAMP;
              div_clr = 1'b1;
            end
          end
        end
        S_RAMP: begin
          // Arrival is confirmed one cycle after the last move so done and busy fall together.
          if (duty_q == target_q) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else if (ramp_tick) begin
            if (duty_q < target_q) duty_d = duty_q + 1'b1;
            else                   duty_d = duty_q - 1'b1;
          end
        end
`ifdef PWM_FADE_BREATHE_EN
        S_BUP: begin
          if (!breathe_i) begin
            state_d  = S_IDLE;
            target_d = duty_q;
          end else if (ramp_tick) begin
            if (duty_q == DUTY_TOP) begin
              duty_d  = duty_q - 1'b1;
              state_d = S_BDOWN;
            end else begin
              duty_d = duty_q + 1'b1;
              if (duty_q == DUTY_TOP_M1) state_d = S_BDOWN;
            end
          end
        end
        S_BDOWN: begin
          if (!breathe_i) begin
            state_d  = S_IDLE;
            target_d = duty_q;
          end else if (ramp_tick) begin
            if (duty_q == '0) begin
              duty_d  = duty_q + 1'b1;
              state_d = S_BUP;
            end else begin
              duty_d = duty_q - 1'b1;
              if (duty_q == DUTY_ONE) state_d = S_BUP;
            end
          end
        end
`endif
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pre_cnt_q <= '0;
      step_q    <= 1'b0;
      div_q     <= '0;
      duty_q    <= '0;
      target_q  <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre_cnt_q <= pre_cnt_d;
      step_q    <= step_d;
      div_q     <= div_d;
      duty_q    <= duty_d;
      target_q  <= target_d;
      done_q    <= done_d;
    end
  end

  assign step_o = step_q;
  assign duty_o = duty_q;
  assign busy_o = busy;
  assign done_o = done_q;

endmodule

// File: doc/pwm_fade_sequencer.md
PWM_FADE_SEQUENCER -- requirements
Module: pwm_fade_sequencer

Interface
REQ-001 Parameter N, default 8: duty width, matching the pwm duty input it drives.
REQ-002 Parameter PRESCALE_W, default 16: width of prescale input.
REQ-003 clk  in  1  single system clock; all state on posedge clk.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 ena  in  1  sequencer enable; low freezes all counters, duty and state.
REQ-006 prescale  in  PRESCALE_W  step period minus 1, in clk cycles.
REQ-007 ramp_div  in  8  step pulses per duty change, minus 1.
REQ-008 cmd_valid  in  1  new target duty offered.
REQ-009 cmd_target  in  N  requested final duty.
REQ-010 cmd_ready  out  1  target accepted when cmd_valid & cmd_ready at posedge clk.
REQ-011 step  out  1  one-cycle tick for the pwm step input.
REQ-012 duty  out  N  current duty, registered, for the pwm duty input.
REQ-013 busy  out  1  high while ramping (state != IDLE).
REQ-014 done  out  1  one-cycle pulse when duty reaches an accepted target.

Function
REQ-015 Prescaler counts 0..prescale while ena=1; step=1 in the cycle the count equals prescale, count then returns to 0.
REQ-016 prescale=0 -> step=1 every cycle while ena=1; ena=0 -> step=0 and prescaler count held.
REQ-017 prescale changed mid-count -> if count > new prescale, count returns to 0 on the next step-enabled cycle with no step pulse.
REQ-018 Ramp divider increments only on step cycles; a ramp tick occurs on the step cycle where the divider equals ramp_div, divider then returns to 0.
REQ-019 States: IDLE, RAMP; encoding is free; BREATHE_UP and BREATHE_DOWN are added per REQ-030.
REQ-020 cmd_ready = 1 exactly when state = IDLE and ena = 1; combinational from state and ena.
REQ-021 Accept in IDLE with cmd_target = duty -> stay IDLE; done = 1 the following cycle.
REQ-022 Accept in IDLE with cmd_target != duty -> target registered; RAMP next cycle; ramp divider cleared to 0.
REQ-023 RAMP: on each ramp tick duty moves by exactly 1 toward target; no wrap at 0 or 2^N-1.
REQ-024 On the tick where duty becomes target -> state IDLE and done = 1 in the following cycle, coincident with busy = 0.
REQ-025 cmd_valid during RAMP is ignored (cmd_ready=0); the sequencer never drops or queues a command.
REQ-026 ena falling mid-RAMP freezes duty, target, state and both counters; ramping resumes exactly where it stopped.

Reset
REQ-027 rst=1 asynchronously sets: state IDLE, duty 0, target 0, prescaler 0, divider 0, step 0, done 0, busy 0.
REQ-028 Reset asserted mid-RAMP aborts the ramp with no done pulse; the first cycle after release behaves as IDLE.

Configuration
REQ-029 Macro PWM_FADE_BREATHE_EN, when defined, adds input breathe (1 bit) after cmd_target.
REQ-030 With macro, breathe=1 in IDLE -> BREATHE_UP: +1 per tick up to 2^N-1, then BREATHE_DOWN: -1 per tick down to 0, repeating; busy=1, cmd_ready=0, no done pulses.
REQ-031 With macro, breathe falling -> IDLE next cycle holding current duty; target set to that duty.
REQ-032 Without macro, no breathe port, no breathe states; behaviour is REQ-015..REQ-028 exactly.

Verification
REQ-033 prescale=3, ena=1 after reset -> step high on cycles 4, 8, 12 after release; ena low 5 cycles -> no step, count held.
REQ-034 prescale=0, ramp_div=0, target 5 from duty 0 -> duty 1..5 on consecutive cycles; done one cycle after duty=5, busy low same cycle.
REQ-035 duty=200, target 198, prescale=1, ramp_div=1 -> duty decrements every 4 cycles to 198, one done pulse; cmd_valid mid-ramp sees cmd_ready=0.
REQ-036 target = current duty 0 -> cmd_ready=1, no RAMP entry, done pulse next cycle, duty stays 0.
REQ-037 Target 255 (N=8) ramp, rst asserted at duty 100 between clock edges -> duty 0 immediately, no done, cmd_ready=1 after release.
REQ-038 With PWM_FADE_BREATHE_EN, breathe=1, prescale=0, ramp_div=0 -> duty 0..255..0 triangle, period 510 cycles; breathe low at duty 37 -> IDLE holding 37.
